fir_xifu_issuer: RTL and testbench



---
 rtl/fir_xifu_pkg.sv | 30 +++
 rtl/fir_xifu_issue_fifo.sv | 56 +++++
 rtl/fir_xifu_issuer.sv | 125 ++++++++++++
 tb/tb_fir_xifu_issuer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU issue-side initiator: FSM states,
// buffered instruction entries and captured issue responses.
package fir_xifu_pkg;

   // Issue/commit sequencing states.
   typedef enum logic [0:0] {
      ISSUE  = 1'b0,
      COMMIT = 1'b1
   } fir_xifu_issuer_state_t;

   // One buffered instruction with its core-register operand values.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } fir_xifu_issuer_entry_t;

   // Coprocessor issue response fields captured at the handshake.
   typedef struct packed {
      logic accept;
      logic writeback;
      logic loadstore;
   } fir_xifu_issue_resp_t;

   // Flatten a response into the {loadstore, writeback, accept} bus order.
   function automatic logic [2:0] pack_resp(input fir_xifu_issue_resp_t r);
      return {r.loadstore, r.writeback, r.accept};
   endfunction

endpackage

// File: rtl/fir_xifu_issue_fifo.sv
// Synchronous FIFO holding pending instructions; a push is refused while
// full even if a pop happens in the same cycle.
module fir_xifu_issue_fifo
   import fir_xifu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fir_xifu_issuer_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  entry_t entry_i,
   input  logic   pop_i,
   output logic   full_o,
   output logic   empty_o,
   output entry_t head_o
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic            push_s;
   logic            pop_s;

   assign push_s  = push_i & ~full_o;
   assign pop_s   = pop_i & ~empty_o;
   assign full_o  = (count_r == (AW+1)'(DEPTH));
   assign empty_o = (count_r == {(AW+1){1'b0}});
   assign head_o  = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (push_s) mem_r[wr_ptr_r] <= entry_i;
   end

endmodule

// File: rtl/fir_xifu_issuer.sv
// XIF issue-side initiator: drives buffered instructions over the issue
// channel, captures the response, then emits a one-cycle commit or kill.
module fir_xifu_issuer
   import fir_xifu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int ID_WIDTH  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 instr_valid_i,
   output logic                 instr_ready_o,
   input  logic [31:0]          instr_i,
   input  logic [31:0]          rs1_i,
   input  logic [31:0]          rs2_i,
   output logic                 issue_valid_o,
   input  logic                 issue_ready_i,
   output logic [31:0]          issue_instr_o,
   output logic [1:0][31:0]     issue_rs_o,
   output logic [ID_WIDTH-1:0]  issue_id_o,
   input  logic                 issue_accept_i,
   input  logic                 issue_writeback_i,
   input  logic                 issue_loadstore_i,
   output logic                 commit_valid_o,
   output logic [ID_WIDTH-1:0]  commit_id_o,
   output logic                 commit_kill_o,
   output logic                 illegal_o,
   output logic [2:0]           resp_o,
   output logic [CNT_WIDTH-1:0] n_accepted_o,
   output logic [CNT_WIDTH-1:0] n_rejected_o
);

   fir_xifu_issuer_state_t  state_r;
   fir_xifu_issuer_state_t  state_n;
   fir_xifu_issuer_entry_t  entry_s;
   fir_xifu_issuer_entry_t  head_s;
   fir_xifu_issue_resp_t    resp_r;
   logic [ID_WIDTH-1:0]     id_r;
   logic [CNT_WIDTH-1:0]    n_acc_r;
   logic [CNT_WIDTH-1:0]    n_rej_r;
   logic                    full_s;
   logic                    empty_s;
   logic                    hs_s;
   logic                    pop_s;

   assign entry_s = '{instr: instr_i, rs1: rs1_i, rs2: rs2_i};

   fir_xifu_issue_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fir_xifu_issuer_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (instr_valid_i),
      .entry_i (entry_s),
      .pop_i   (pop_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .head_o  (head_s)
   );

   // The head is only popped at the end of COMMIT, so request fields stay
   // stable for the whole time the issue request is pending.
   assign hs_s  = (state_r == ISSUE) & ~empty_s & issue_ready_i;
   assign pop_s = (state_r == COMMIT);

   assign instr_ready_o  = ~full_s;
   assign issue_valid_o  = (state_r == ISSUE) & ~empty_s;
   assign issue_instr_o  = head_s.instr;
   assign issue_rs_o[0]  = head_s.rs1;
   assign issue_rs_o[1]  = head_s.rs2;
   assign issue_id_o     = id_r;
   assign commit_valid_o = (state_r == COMMIT);
   assign commit_id_o    = id_r;
   assign commit_kill_o  = (state_r == COMMIT) & ~resp_r.accept;
   assign illegal_o      = (state_r == COMMIT) & ~resp_r.accept;
   assign resp_o         = pack_resp(resp_r);
   assign n_accepted_o   = n_acc_r;
   assign n_rejected_o   = n_rej_r;

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= ISSUE;
      else       state_r <= state_n;
   end

   // Next state: leave ISSUE on a handshake; COMMIT always lasts one cycle.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ISSUE: begin
            if (hs_s) state_n = COMMIT;
            else      state_n = ISSUE;
         end
         COMMIT:  state_n = ISSUE;
         default: state_n = ISSUE;
      endcase
   end

   // Response capture, id sequencing and saturating statistics.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_r  <= '{accept: 1'b0, writeback: 1'b0, loadstore: 1'b0};
         id_r    <= {ID_WIDTH{1'b0}};
         n_acc_r <= {CNT_WIDTH{1'b0}};
         n_rej_r <= {CNT_WIDTH{1'b0}};
      end else begin
         if (hs_s) begin
            resp_r <= '{accept:    issue_accept_i,
                        writeback: issue_writeback_i,
                        loadstore: issue_loadstore_i};
         end
         if (pop_s) begin
            id_r <= id_r + ID_WIDTH'(1);
            if (resp_r.accept) begin
               if (n_acc_r != {CNT_WIDTH{1'b1}}) n_acc_r <= n_acc_r + CNT_WIDTH'(1);
            end else begin
               if (n_rej_r != {CNT_WIDTH{1'b1}}) n_rej_r <= n_rej_r + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_xifu_issuer.sv
// Scoreboard bench for fir_xifu_issuer: stimulus queues expected issue
// requests; a negedge monitor checks every issue handshake and commit.
module tb_fir_xifu_issuer;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             instr_valid_i;
   logic             instr_ready_o;
   logic [31:0]      instr_i, rs1_i, rs2_i;
   logic             issue_valid_o;
   logic             issue_ready_i;
   logic [31:0]      issue_instr_o;
   logic [1:0][31:0] issue_rs_o;
   logic [3:0]       issue_id_o;
   logic             issue_accept_i, issue_writeback_i, issue_loadstore_i;
   logic             commit_valid_o;
   logic [3:0]       commit_id_o;
   logic             commit_kill_o;
   logic             illegal_o;
   logic [2:0]       resp_o;
   logic [15:0]      n_accepted_o, n_rejected_o;

   always #5 clk_i = ~clk_i;

   fir_xifu_issuer #(.DEPTH(4), .ID_WIDTH(4), .CNT_WIDTH(16)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .instr_valid_i     (instr_valid_i),
      .instr_ready_o     (instr_ready_o),
      .instr_i           (instr_i),
      .rs1_i             (rs1_i),
      .rs2_i             (rs2_i),
      .issue_valid_o     (issue_valid_o),
      .issue_ready_i     (issue_ready_i),
      .issue_instr_o     (issue_instr_o),
      .issue_rs_o        (issue_rs_o),
      .issue_id_o        (issue_id_o),
      .issue_accept_i    (issue_accept_i),
      .issue_writeback_i (issue_writeback_i),
      .issue_loadstore_i (issue_loadstore_i),
      .commit_valid_o    (commit_valid_o),
      .commit_id_o       (commit_id_o),
      .commit_kill_o     (commit_kill_o),
      .illegal_o         (illegal_o),
      .resp_o            (resp_o),
      .n_accepted_o      (n_accepted_o),
      .n_rejected_o      (n_rejected_o)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  id;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  exp_id   = 4'd0;
   logic        commit_pend = 1'b0;
   logic [3:0]  cm_id;
   logic        cm_kill;
   logic [2:0]  cm_resp;
   logic [15:0] acc_m = 16'd0;
   logic [15:0] rej_m = 16'd0;
   logic        hold_v = 1'b0;
   logic [31:0] hold_instr;
   logic [3:0]  hold_id;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: check commits and issue handshakes against the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (commit_pend) begin
            chk("commit_valid", 64'(commit_valid_o), 64'd1);
            chk("commit_id", 64'(commit_id_o), 64'(cm_id));
            chk("commit_kill", 64'(commit_kill_o), 64'(cm_kill));
            chk("illegal", 64'(illegal_o), 64'(cm_kill));
            chk("resp", 64'(resp_o), 64'(cm_resp));
            chk("valid_in_commit", 64'(issue_valid_o), 64'd0);
            chk("n_accepted_mon", 64'(n_accepted_o), 64'(acc_m));
            chk("n_rejected_mon", 64'(n_rejected_o), 64'(rej_m));
            if (cm_kill) rej_m = rej_m + 16'd1;
            else         acc_m = acc_m + 16'd1;
            commit_pend = 1'b0;
         end else begin
            chk("idle_commit_outs", 64'({commit_valid_o, commit_kill_o, illegal_o}), 64'd0);
         end
         if (issue_valid_o && issue_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("issue_instr", 64'(issue_instr_o), 64'(mon_e.instr));
               chk("issue_rs0", 64'(issue_rs_o[0]), 64'(mon_e.rs1));
               chk("issue_rs1", 64'(issue_rs_o[1]), 64'(mon_e.rs2));
               chk("issue_id", 64'(issue_id_o), 64'(mon_e.id));
               commit_pend = 1'b1;
               cm_id   = mon_e.id;
               cm_kill = ~issue_accept_i;
               cm_resp = {issue_loadstore_i, issue_writeback_i, issue_accept_i};
            end
            hold_v = 1'b0;
         end else if (issue_valid_o) begin
            if (hold_v) begin
               chk("stall_instr", 64'(issue_instr_o), 64'(hold_instr));
               chk("stall_id", 64'(issue_id_o), 64'(hold_id));
            end
            hold_v     = 1'b1;
            hold_instr = issue_instr_o;
            hold_id    = issue_id_o;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   task automatic clear_model();
      exp_q.delete();
      exp_id      = 4'd0;
      commit_pend = 1'b0;
      hold_v      = 1'b0;
      acc_m       = 16'd0;
      rej_m       = 16'd0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      instr_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      clear_model();
      rst_i = 1'b0;
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, output int waits);
      @(negedge clk_i);
      instr_i = ins; rs1_i = r1; rs2_i = r2;
      instr_valid_i = 1'b1;
      waits = 0;
      while (!instr_ready_o && waits < 50) begin
         @(negedge clk_i);
         waits++;
      end
      if (!instr_ready_o) begin
         instr_valid_i = 1'b0;
         chk("push_timeout", 64'd0, 64'd1);
      end else begin
         exp_q.push_back('{instr: ins, rs1: r1, rs2: r2, id: exp_id});
         exp_id = exp_id + 4'd1;
         @(posedge clk_i);
         #1;
         instr_valid_i = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || commit_pend) && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
      @(negedge clk_i);
   endtask

   initial begin
      int w;
      int n;
      rst_i = 1'b1; instr_valid_i = 1'b0;
      instr_i = 32'd0; rs1_i = 32'd0; rs2_i = 32'd0;
      issue_ready_i = 1'b0; issue_accept_i = 1'b0;
      issue_writeback_i = 1'b0; issue_loadstore_i = 1'b0;
      do_reset();

      // Reset values
      @(negedge clk_i);
      chk("rst_instr_ready", 64'(instr_ready_o), 64'd1);
      chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
      chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
      chk("rst_kill_illegal", 64'({commit_kill_o, illegal_o}), 64'd0);
      chk("rst_resp", 64'(resp_o), 64'd0);
      chk("rst_counters", 64'({n_accepted_o, n_rejected_o}), 64'd0);
      chk("rst_id", 64'(issue_id_o), 64'd0);

      // Single accepted xfirdotp
      issue_ready_i = 1'b1; issue_accept_i = 1'b1; issue_writeback_i = 1'b1;
      push(32'h0020_850B, 32'h0000_1234, 32'h0000_5678, w);
      @(negedge clk_i);
      chk("t1_valid_latency", 64'(issue_valid_o), 64'd1);
      chk("t1_id0", 64'(issue_id_o), 64'd0);
      @(negedge clk_i);
      chk("t1_commit", 64'({commit_valid_o, commit_kill_o}), 64'b10);
      @(negedge clk_i);
      chk("t1_n_accepted", 64'(n_accepted_o), 64'd1);

      // Rejected instruction with an unsupported funct3
      issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
      push(32'h0020_F50B, 32'hDEAD_BEEF, 32'h0BAD_F00D, w);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t2_kill_illegal", 64'({commit_kill_o, illegal_o}), 64'b11);
      @(negedge clk_i);
      chk("t2_illegal_pulse", 64'(illegal_o), 64'd0);
      chk("t2_n_rejected", 64'(n_rejected_o), 64'd1);
      chk("t2_n_accepted", 64'(n_accepted_o), 64'd1);

      // Stall with three entries queued
      do_reset();
      issue_ready_i = 1'b0; issue_accept_i = 1'b1; issue_writeback_i = 1'b1;
      issue_loadstore_i = 1'b1;
      push(32'h1111_000B, 32'h1, 32'h2, w);
      push(32'h2222_000B, 32'h3, 32'h4, w);
      push(32'h3333_000B, 32'h5, 32'h6, w);
      repeat (5) begin
         @(negedge clk_i);
         chk("t3_stall_valid", 64'(issue_valid_o), 64'd1);
         chk("t3_stall_head", 64'({issue_instr_o, 28'd0, issue_id_o}), {32'h1111_000B, 32'd0});
      end
      issue_ready_i = 1'b1;
      wait_idle();
      chk("t3_n_accepted", 64'(n_accepted_o), 64'd3);

      // Full buffer refuses the 5th push until the first commit pops
      do_reset();
      issue_ready_i = 1'b0; issue_loadstore_i = 1'b0;
      for (int i = 0; i < 4; i++) push(32'hA000_000B + 32'(i), 32'(i), 32'(i + 100), w);
      @(negedge clk_i);
      chk("t4_full_ready", 64'(instr_ready_o), 64'd0);
      issue_ready_i = 1'b1;
      push(32'hA000_0FFB, 32'd55, 32'd66, w);
      chk("t4_fifth_waited", 64'(w > 0), 64'd1);
      @(negedge clk_i);
      chk("t4_after_first_commit", 64'(n_accepted_o), 64'd1);
      wait_idle();
      chk("t4_n_accepted", 64'(n_accepted_o), 64'd5);

      // Id wrap over 18 instructions
      do_reset();
      for (int i = 0; i < 18; i++) push(32'hB000_000B + 32'(i << 12), 32'(i), 32'(~i), w);
      wait_idle();
      chk("t5_n_accepted", 64'(n_accepted_o), 64'd18);
      chk("t5_next_id", 64'(issue_id_o), 64'd2);

      // Reset in the COMMIT cycle
      do_reset();
      push(32'hC000_000B, 32'd7, 32'd8, w);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!commit_valid_o && n < 10);
      chk("t6_reached_commit", 64'(commit_valid_o), 64'd1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_model();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("t6_rst_commit", 64'({commit_valid_o, commit_kill_o, illegal_o}), 64'd0);
      chk("t6_rst_issue", 64'({issue_valid_o, instr_ready_o}), 64'b01);
      chk("t6_rst_resp_cnt", 64'({resp_o, n_accepted_o, n_rejected_o}), 64'd0);
      chk("t6_rst_id", 64'(issue_id_o), 64'd0);
      push(32'hD000_000B, 32'd9, 32'd10, w);
      @(negedge clk_i);
      chk("t6_new_id0", 64'({issue_valid_o, issue_id_o}), 64'b10000);
      wait_idle();
      chk("t6_n_accepted", 64'(n_accepted_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
